// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage.
//   dm_req   : request, held until the edge on which dm_ack is sampled high
//   dm_we    : 1 = store, 0 = load
//   dm_be    : byte enables, bit i covers bits 8i+7:8i (little-endian)
//   dm_addr  : word address, low two bits always zero
//   dm_wdata : store data already replicated across the lanes
//   dm_ack   : memory completes the outstanding request this cycle
//   dm_rdata : full read word, valid together with dm_ack
// master = pipeline stage, slave = memory.
interface mem_access_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage of the 32-bit core.
// Accepts one instruction from EX while idle. Non-memory ops and misaligned
// accesses are passed to writeback on the next edge. Aligned loads and stores
// are issued on the dm port, and the stage waits for dm_ack. The wait is
// abandoned after TIMEOUT cycles without an ack, and the result is flagged
// with out_err. Load data is returned right-aligned and zero-extended. Sign
// extension happens later, in the writeback mux.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : EX handshake (ready only in IDLE, low during reset)
//   in_op/alu_result/store_data/rd : EX results
//   dm              : data-memory port (master side)
//   out_valid       : one-cycle pulse, out_* fields are valid
//   out_op/alu_result/dm_data/rd   : registered results, held between pulses
//   out_misalign    : access was misaligned and was not issued
//   out_err         : access timed out
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [5:0]          in_op,
  input  logic [31:0]         in_alu_result,
  input  logic [31:0]         in_store_data,
  input  logic [4:0]          in_rd,
  mem_access_stage_if.master  dm,
  output logic                out_valid,
  output logic [5:0]          out_op,
  output logic [31:0]         out_alu_result,
  output logic [31:0]         out_dm_data,
  output logic [4:0]          out_rd,
  output logic                out_misalign,
  output logic                out_err
);
  localparam logic [5:0] OP_LW = 6'd16;
  localparam logic [5:0] OP_LH = 6'd18;
  localparam logic [5:0] OP_LB = 6'd20;
  localparam logic [5:0] OP_SW = 6'd24;
  localparam logic [5:0] OP_SH = 6'd26;
  localparam logic [5:0] OP_SB = 6'd28;
  localparam int         CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {IDLE, WAIT} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   wait_cnt;
  logic [5:0]         hold_op;
  logic [31:0]        hold_alu;
  logic [4:0]         hold_rd;

  logic               is_mem, misaligned;
  logic [3:0]         be_c;
  logic [31:0]        wdata_c, load_data;
  logic               pass_through, issue, done_ack, done_timeout;

  assign in_ready = (state == IDLE) && !rst;

  // Decode of the instruction offered by EX.
  // NOTE: every signal driven from always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    is_mem     = 1'b0;
    misaligned = 1'b0;
    be_c       = 4'b0000;
    wdata_c    = in_store_data;
    case (in_op)
      OP_LW, OP_SW: begin
        is_mem     = 1'b1;
        misaligned = (in_alu_result[1:0] != 2'b00);
        be_c       = 4'b1111;
      end
      OP_LH, OP_SH: begin
        is_mem     = 1'b1;
        misaligned = in_alu_result[0];
        be_c       = in_alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_c    = {2{in_store_data[15:0]}};
      end
      OP_LB, OP_SB: begin
        is_mem     = 1'b1;
        be_c       = 4'b0001 << in_alu_result[1:0];
        wdata_c    = {4{in_store_data[7:0]}};
      end
      default: ;
    endcase
  end

  // Right-align the returned word using the address held during WAIT.
  always_comb begin
    load_data = 32'h0;
    case (hold_op)
      OP_LW:   load_data = dm.dm_rdata;
      OP_LH:   load_data = {16'h0, hold_alu[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0]};
      OP_LB:   load_data = {24'h0, dm.dm_rdata[{hold_alu[1:0], 3'b000} +: 8]};
      default: load_data = 32'h0;
    endcase
  end

  // Next-state logic. An ack in the last allowed WAIT cycle beats the timeout.
  always_comb begin
    state_next   = state;
    pass_through = 1'b0;
    issue        = 1'b0;
    done_ack     = 1'b0;
    done_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem || misaligned) begin
            pass_through = 1'b1;
          end else begin
            issue      = 1'b1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (dm.dm_ack) begin
          done_ack   = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          done_timeout = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every register here is a control or output flop, with no memory array, so all of them are cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt       <= '0;
      hold_op        <= '0;
      hold_alu       <= '0;
      hold_rd        <= '0;
      dm.dm_req      <= 1'b0;
      dm.dm_we       <= 1'b0;
      dm.dm_be       <= '0;
      dm.dm_addr     <= '0;
      dm.dm_wdata    <= '0;
      out_valid      <= 1'b0;
      out_op         <= '0;
      out_alu_result <= '0;
      out_dm_data    <= '0;
      out_rd         <= '0;
      out_misalign   <= 1'b0;
      out_err        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (pass_through) begin
        out_valid      <= 1'b1;
        out_op         <= in_op;
        out_alu_result <= in_alu_result;
        out_rd         <= in_rd;
        out_dm_data    <= '0;
        out_misalign   <= is_mem;
        out_err        <= 1'b0;
      end
      if (issue) begin
        hold_op     <= in_op;
        hold_alu    <= in_alu_result;
        hold_rd     <= in_rd;
        wait_cnt    <= '0;
        dm.dm_req   <= 1'b1;
        dm.dm_we    <= (in_op == OP_SW) || (in_op == OP_SH) || (in_op == OP_SB);
        dm.dm_be    <= be_c;
        dm.dm_addr  <= {in_alu_result[31:2], 2'b00};
        dm.dm_wdata <= wdata_c;
      end
      if (done_ack || done_timeout) begin
        dm.dm_req      <= 1'b0;
        out_valid      <= 1'b1;
        out_op         <= hold_op;
        out_alu_result <= hold_alu;
        out_rd         <= hold_rd;
        out_dm_data    <= (done_ack && !dm.dm_we) ? load_data : 32'h0;
        out_misalign   <= 1'b0;
        out_err        <= done_timeout;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
endmodule
